// File: rtl/uart_rx_deser.sv
// 8N1 UART receiver: synchronizes the RX pin, deserializes LSB-first frames
// and buffers completed bytes in a small FIFO drained by a valid/ready handshake.
module uart_rx_deser #(
    parameter int CLK_DIV    = 234,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx_i,
    output logic [7:0]                    rx_data_o,
    output logic                          rx_valid_o,
    input  logic                          rx_ready_i,
    output logic                          frame_err_o,
    output logic                          overflow_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state, state_next;
    logic          sync1, sync2, sync2_d;
    logic [1:0]    settle;
    logic          fall_edge;
    logic [CW-1:0] cnt, cnt_next;
    logic [2:0]    bit_idx, bit_idx_next;
    logic [7:0]    shift_reg, shift_next;
    logic          push;
    logic          frame_err_next;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wptr, rptr;
    logic          full, empty, pop, do_push;

    // settle keeps WAIT_IDLE from trusting the forced-high synchronizer
    // values in the first cycles after reset, so a line held low through
    // reset release is not mistaken for a start edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            sync2_d <= 1'b1;
            settle  <= 2'b00;
        end else begin
            sync1   <= rx_i;
            sync2   <= sync1;
            sync2_d <= sync2;
            settle  <= {settle[0], 1'b1};
        end
    end

    assign fall_edge = !sync2 && sync2_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= WAIT_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            bit_idx   <= bit_idx_next;
            shift_reg <= shift_next;
        end
    end

    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        bit_idx_next   = bit_idx;
        shift_next     = shift_reg;
        push           = 1'b0;
        frame_err_next = 1'b0;
        case (state)
            WAIT_IDLE: begin
                if (settle[1] && sync2) state_next = IDLE;
            end
            IDLE: begin
                if (fall_edge) begin
                    state_next = START;
                    cnt_next   = HALF_LOAD;
                end
            end
            START: begin
                if (cnt != '0) begin
                    cnt_next = cnt - 1'b1;
                end else if (sync2) begin
                    state_next = IDLE;
                end else begin
                    state_next   = DATA;
                    cnt_next     = FULL_LOAD;
                    bit_idx_next = '0;
                end
            end
            DATA: begin
                if (cnt != '0) begin
                    cnt_next = cnt - 1'b1;
                end else begin
                    shift_next   = {sync2, shift_reg[7:1]};
                    cnt_next     = FULL_LOAD;
                    bit_idx_next = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_next = STOP;
                end
            end
            STOP: begin
                if (cnt != '0) begin
                    cnt_next = cnt - 1'b1;
                end else if (sync2) begin
                    push       = 1'b1;
                    state_next = IDLE;
                end else begin
                    frame_err_next = 1'b1;
                    state_next     = WAIT_IDLE;
                end
            end
            default: state_next = WAIT_IDLE;
        endcase
    end

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop     = !empty && rx_ready_i;
    // A pop in the same cycle frees the slot the incoming byte lands in.
    assign do_push = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr        <= '0;
            rptr        <= '0;
            mem         <= '{default: '0};
            frame_err_o <= 1'b0;
            overflow_o  <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wptr[AW-1:0]] <= shift_reg;
                wptr              <= wptr + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
            frame_err_o <= frame_err_next;
            overflow_o  <= push && full && !pop;
        end
    end

    assign rx_data_o    = mem[rptr[AW-1:0]];
    assign rx_valid_o   = !empty;
    assign fifo_count_o = wptr - rptr;

endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed bench for uart_rx_deser: drives 8N1 frames at 8680 ns/bit on a
// ~27 MHz clock and checks popped bytes, flags, occupancy and latency.
`timescale 1ns/1ps
module tb_uart_rx_deser;

    localparam int CLK_DIV    = 234;
    localparam int FIFO_DEPTH = 4;
    localparam int BIT_NS     = 8680;

    logic       clk;
    logic       rst_n;
    logic       rx_i;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_ready_i;
    logic       frame_err_o;
    logic       overflow_o;
    logic [$clog2(FIFO_DEPTH):0] fifo_count_o;

    uart_rx_deser #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_i         (rx_i),
        .rx_data_o    (rx_data_o),
        .rx_valid_o   (rx_valid_o),
        .rx_ready_i   (rx_ready_i),
        .frame_err_o  (frame_err_o),
        .overflow_o   (overflow_o),
        .fifo_count_o (fifo_count_o)
    );

    initial clk = 1'b0;
    always #18.5 clk = ~clk;

    int n_compared = 0;
    int n_mismatch = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] popped [$];
    int   valid_cycles;
    int   ferr_cnt;
    int   ovf_cnt;
    int   max_count;
    int   rise_cyc;
    int   start_cyc;
    logic prev_valid = 1'b0;

    // Observe the handshake and flag pulses mid-cycle, away from the clock edge.
    always @(negedge clk) begin
        if (rx_valid_o && rx_ready_i) popped.push_back(rx_data_o);
        if (rx_valid_o) valid_cycles++;
        if (frame_err_o) ferr_cnt++;
        if (overflow_o) ovf_cnt++;
        if (int'(fifo_count_o) > max_count) max_count = int'(fifo_count_o);
        if (rx_valid_o && !prev_valid && rise_cyc < 0) rise_cyc = cyc;
        prev_valid = rx_valid_o;
    end

    task automatic clearMonitor();
        popped.delete();
        valid_cycles = 0;
        ferr_cnt     = 0;
        ovf_cnt      = 0;
        max_count    = 0;
        rise_cyc     = -1;
    endtask

    function automatic logic [7:0] getPop(input int i);
        if (popped.size() > i) return popped[i];
        return 8'hxx;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatch++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Sends one frame; stop_low_bits > 0 holds the line low that many bit-times
    // from the stop bit on, reset_at_bit >= 0 pulses rst_n inside that bit.
    task automatic applyStimulus(input logic [7:0] data, input int stop_low_bits,
                                 input int reset_at_bit);
        logic b;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        for (int i = 0; i < 10; i++) begin
            if (i == 0)      b = 1'b0;
            else if (i < 9)  b = data[i-1];
            else             b = (stop_low_bits == 0);
            rx_i = b;
            if (i == reset_at_bit) begin
                #3000;
                @(posedge clk);
                #1 rst_n = 1'b0;
                @(posedge clk);
                #1 rst_n = 1'b1;
                #(BIT_NS - 3100);
            end else begin
                #(BIT_NS);
            end
        end
        if (stop_low_bits > 1) #(BIT_NS * (stop_low_bits - 1));
        rx_i = 1'b1;
    endtask

    logic [7:0] burst [5];
    int lat;

    initial begin
        rx_i       = 1'b1;
        rst_n      = 1'b0;
        rx_ready_i = 1'b0;
        clearMonitor();
        #320000;
        @(posedge clk);
        #1;
        checkOutput("reset_valid", rx_valid_o, 0);
        checkOutput("reset_count", fifo_count_o, 0);
        checkOutput("reset_ferr", frame_err_o, 0);
        checkOutput("reset_ovf", overflow_o, 0);
        checkOutput("reset_data", rx_data_o, 0);
        rst_n      = 1'b1;
        rx_ready_i = 1'b1;
        repeat (10) @(posedge clk);
        #1 clearMonitor();

        $display("[TB] single byte 0x41");
        applyStimulus(8'h41, 0, -1);
        repeat (20) @(posedge clk);
        #1;
        lat = rise_cyc - start_cyc - 1;
        checkOutput("t1_pops", popped.size(), 1);
        checkOutput("t1_data", getPop(0), 8'h41);
        checkOutput("t1_valid_cycles", valid_cycles, 1);
        checkOutput("t1_ferr", ferr_cnt, 0);
        checkOutput("t1_ovf", ovf_cnt, 0);
        checkOutput("t1_latency_2225pm1", (lat >= 2224 && lat <= 2226), 1);

        $display("[TB] back-to-back burst");
        burst = '{8'h41, 8'h42, 8'h43, 8'h0D, 8'h0A};
        clearMonitor();
        for (int i = 0; i < 5; i++) applyStimulus(burst[i], 0, -1);
        repeat (20) @(posedge clk);
        #1;
        checkOutput("t2_pops", popped.size(), 5);
        checkOutput("t2_data", {getPop(0), getPop(1), getPop(2), getPop(3), getPop(4)},
                    40'h41_42_43_0D_0A);
        checkOutput("t2_max_count", max_count, 1);
        checkOutput("t2_flags", ferr_cnt + ovf_cnt, 0);

        $display("[TB] overflow with ready low");
        rx_ready_i = 1'b0;
        clearMonitor();
        for (int i = 0; i < 5; i++) applyStimulus(8'h10 + 8'(i), 0, -1);
        repeat (20) @(posedge clk);
        #1;
        checkOutput("t3_count_full", fifo_count_o, 4);
        checkOutput("t3_ovf_pulses", ovf_cnt, 1);
        checkOutput("t3_ferr", ferr_cnt, 0);
        checkOutput("t3_head", rx_data_o, 8'h10);
        rx_ready_i = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("t3_pops", popped.size(), 4);
        checkOutput("t3_data", {getPop(0), getPop(1), getPop(2), getPop(3)}, 32'h10_11_12_13);
        checkOutput("t3_count_drained", fifo_count_o, 0);

        $display("[TB] glitch and low line through reset");
        clearMonitor();
        rx_i = 1'b0;
        repeat (50) @(posedge clk);
        #1 rx_i = 1'b1;
        repeat (400) @(posedge clk);
        #1;
        checkOutput("t4_glitch_pops", popped.size(), 0);
        checkOutput("t4_glitch_flags", ferr_cnt + ovf_cnt, 0);
        rx_i  = 1'b0;
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3000) @(posedge clk);
        #1;
        checkOutput("t4_lowreset_ferr", ferr_cnt, 0);
        checkOutput("t4_lowreset_valid", valid_cycles, 0);
        rx_i = 1'b1;
        repeat (20) @(posedge clk);
        applyStimulus(8'h5A, 0, -1);
        repeat (20) @(posedge clk);
        #1;
        checkOutput("t4_after_pops", popped.size(), 1);
        checkOutput("t4_after_data", getPop(0), 8'h5A);
        checkOutput("t4_after_flags", ferr_cnt + ovf_cnt, 0);

        $display("[TB] framing error");
        clearMonitor();
        applyStimulus(8'h55, 2, -1);
        repeat (20) @(posedge clk);
        #1;
        checkOutput("t5_ferr", ferr_cnt, 1);
        checkOutput("t5_count", fifo_count_o, 0);
        checkOutput("t5_no_pop", popped.size(), 0);
        applyStimulus(8'h33, 0, -1);
        repeat (20) @(posedge clk);
        #1;
        checkOutput("t5_next_pops", popped.size(), 1);
        checkOutput("t5_next_data", getPop(0), 8'h33);
        checkOutput("t5_ferr_once", ferr_cnt, 1);

        $display("[TB] reset mid-frame");
        rx_ready_i = 1'b0;
        clearMonitor();
        applyStimulus(8'h21, 0, -1);
        applyStimulus(8'h22, 0, -1);
        repeat (20) @(posedge clk);
        #1;
        checkOutput("t6_buffered", fifo_count_o, 2);
        applyStimulus(8'hF8, 0, 4);
        repeat (300) @(posedge clk);
        #1;
        checkOutput("t6_count", fifo_count_o, 0);
        checkOutput("t6_valid", rx_valid_o, 0);
        checkOutput("t6_flags", ferr_cnt + ovf_cnt, 0);
        rx_ready_i = 1'b1;
        applyStimulus(8'hA5, 0, -1);
        repeat (20) @(posedge clk);
        #1;
        checkOutput("t6_pops", popped.size(), 1);
        checkOutput("t6_data", getPop(0), 8'hA5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
